ucaspian_dendrite: RTL

Delay-line charge accumulator sitting between the synapse stage and `ucaspian_neuron`; it is the transmitting end of the neuron's `neuron_addr/neuron_charge/neuron_vld/neuron_rdy` input port. Weighted synaptic events are summed per target neuron into a ring of delay slots. On each `next_step`, the current slot is drained: every non-zero accumulated charge is sent to the neuron and then zeroed. Activity clearing mirrors the neuron's `clear_act`/`clear_done` protocol.

---
 rtl/ucaspian_dendrite.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ucaspian_dendrite.sv
`timescale 1ns/1ps
// ucaspian_dendrite
//   Delay-line charge accumulator placed in front of ucaspian_neuron.
//   Weighted synaptic events are summed per target neuron into a ring of
//   2^DELAY_BITS delay slots. Each next_step drains the current slot: every
//   non-zero charge is handed to the neuron and the entry is zeroed.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
//   valid && ready are both high. While valid is high and ready is low the
//   sender holds its payload stable. Here syn_vld/syn_rdy is the inbound
//   event port (this block is the receiver) and neuron_vld/neuron_rdy is the
//   outbound drain port (this block is the sender).
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   enable                     gates syn_rdy and the latching of next_step
//   clear_act / clear_done     level request to zero every slot / completion
//   next_step / step_done      drain request pulse / idle-with-nothing-pending
//   syn_addr/weight/delay      event target, signed weight, delay in steps
//   syn_vld / syn_rdy          event handshake
//   neuron_addr/charge         drained address and signed accumulated charge
//   neuron_vld / neuron_rdy    drain handshake
module ucaspian_dendrite #(
   parameter int NUM_NEURONS = 256,
   parameter int DELAY_BITS  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear_act,
   output logic                  clear_done,
   input  logic                  next_step,
   output logic                  step_done,
   input  logic [7:0]            syn_addr,
   input  logic [7:0]            syn_weight,
   input  logic [DELAY_BITS-1:0] syn_delay,
   input  logic                  syn_vld,
   output logic                  syn_rdy,
   output logic [7:0]            neuron_addr,
   output logic [15:0]           neuron_charge,
   output logic                  neuron_vld,
   input  logic                  neuron_rdy
);

   localparam int AW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int IW    = DELAY_BITS + AW;
   localparam int DEPTH = 1 << IW;
   localparam logic [AW-1:0] LAST_N = AW'(NUM_NEURONS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACC_RD,
      S_ACC_WR,
      S_DR_RD,
      S_DR_CHK,
      S_DR_OUT,
      S_CLR
   } state_t;

   state_t                  state, state_n;
   logic [DELAY_BITS-1:0]   cur;
   logic [AW-1:0]           n;
   logic                    step_pending;
   logic [IW-1:0]           acc_idx;
   logic [7:0]              acc_w;
   logic [IW-1:0]           clr_idx;

   // accumulator storage, registered read port
   logic [15:0]             mem [DEPTH];
   logic [15:0]             rd_data;
   logic [IW-1:0]           rd_idx;
   logic                    mem_we;
   logic [IW-1:0]           mem_wa;
   logic [15:0]             mem_wd;

   logic                    accept;
   logic                    advance;
   logic                    force_clr;
   logic [DELAY_BITS-1:0]   tgt_slot;
   logic [16:0]             sum;
   logic [15:0]             sat_sum;

   assign tgt_slot = cur + syn_delay;

   // 17-bit sum; the two top bits disagree exactly when 16 bits overflow
   assign sum     = {rd_data[15], rd_data} + {{9{acc_w[7]}}, acc_w};
   assign sat_sum = (sum[16] != sum[15]) ? (sum[16] ? 16'h8000 : 16'h7fff)
                                         : sum[15:0];

   // reset term keeps syn_rdy low while the block is held in reset
   assign syn_rdy = !reset && (state == S_IDLE) && enable && !clear_act &&
                    !step_pending;
   assign accept  = syn_rdy && syn_vld;

   always_comb begin
      state_n   = state;
      rd_idx    = acc_idx;
      mem_we    = 1'b0;
      mem_wa    = acc_idx;
      mem_wd    = '0;
      advance   = 1'b0;
      force_clr = clear_act && (state != S_CLR);
      case (state)
         S_IDLE: begin
            if (clear_act) begin
               state_n = S_CLR;
            end else if (step_pending) begin
               state_n = S_DR_RD;
            end else if (accept) begin
               rd_idx  = {tgt_slot, syn_addr[AW-1:0]};
               state_n = S_ACC_RD;
            end
         end
         S_ACC_RD: begin
            rd_idx  = acc_idx;
            state_n = S_ACC_WR;
         end
         S_ACC_WR: begin
            mem_we  = 1'b1;
            mem_wa  = acc_idx;
            mem_wd  = sat_sum;
            state_n = S_IDLE;
         end
         S_DR_RD: begin
            rd_idx  = {cur, n};
            state_n = S_DR_CHK;
         end
         S_DR_CHK: begin
            if (rd_data == 16'd0) begin
               advance = 1'b1;
            end else begin
               state_n = S_DR_OUT;
            end
         end
         S_DR_OUT: begin
            if (neuron_rdy) begin
               mem_we  = 1'b1;
               mem_wa  = {cur, n};
               mem_wd  = '0;
               advance = 1'b1;
            end
         end
         S_CLR: begin
            if (!clear_done) begin
               mem_we = 1'b1;
               mem_wa = clr_idx;
               mem_wd = '0;
            end else if (!clear_act) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (advance) begin
         state_n = (n == LAST_N) ? S_IDLE : S_DR_RD;
      end
      // a clear request aborts whatever is in flight
      if (force_clr) begin
         state_n = S_CLR;
         advance = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         cur           <= '0;
         n             <= '0;
         step_pending  <= 1'b0;
         acc_idx       <= '0;
         acc_w         <= '0;
         clr_idx       <= '0;
         clear_done    <= 1'b0;
         step_done     <= 1'b0;
         neuron_vld    <= 1'b0;
         neuron_addr   <= '0;
         neuron_charge <= '0;
      end else begin
         state     <= state_n;
         step_done <= (state == S_IDLE) && !step_pending && !clear_act;

         // a fresh pulse wins over the drain-start clear so it is not lost
         if (state == S_CLR && !clear_done && (&clr_idx)) begin
            step_pending <= 1'b0;
         end else if (enable && next_step) begin
            step_pending <= 1'b1;
         end else if (state == S_IDLE && state_n == S_DR_RD) begin
            step_pending <= 1'b0;
         end

         if (state == S_IDLE && state_n == S_ACC_RD) begin
            acc_idx <= rd_idx;
            acc_w   <= syn_weight;
         end

         if (state == S_IDLE && state_n == S_DR_RD) begin
            n <= '0;
         end

         if (advance) begin
            if (n == LAST_N) begin
               cur <= cur + 1'b1;
            end else begin
               n <= n + 1'b1;
            end
         end

         if (state == S_DR_CHK && state_n == S_DR_OUT) begin
            neuron_vld    <= 1'b1;
            neuron_addr   <= 8'(n);
            neuron_charge <= rd_data;
         end else if (state == S_DR_OUT && (neuron_rdy || force_clr)) begin
            neuron_vld <= 1'b0;
         end

         if (force_clr) begin
            clr_idx    <= '0;
            clear_done <= 1'b0;
         end else if (state == S_CLR) begin
            if (!clear_done) begin
               clr_idx <= clr_idx + 1'b1;
               if (&clr_idx) begin
                  clear_done <= 1'b1;
                  cur        <= '0;
               end
            end else if (!clear_act) begin
               clear_done <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
      rd_data <= mem[rd_idx];
   end

endmodule
